// File: rtl/river_cross_game_ctrl.sv
// Farmer/wolf/goat/cabbage river crossing controller: one move per request,
// legality check, registered safety alarm, move counter and WON/LOST tracking.
module river_cross_game_ctrl #(
  parameter int MOVE_W     = 5,
  parameter int MAX_MOVES  = 31,
  parameter int TIMEOUT_EN = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              restart,
  input  logic              move_valid,
  input  logic [1:0]        move_sel,
  output logic [3:0]        pos,
  output logic              alarm,
  output logic              move_err,
  output logic [MOVE_W-1:0] move_cnt,
  output logic              won,
  output logic              lost,
  output logic              timeout
);

  // state | meaning
  // PLAY  | game in progress, moves accepted
  // WON   | everyone on the far bank, moves rejected
  // LOST  | unsafe bank or move limit reached, moves rejected
  localparam logic [1:0] S_PLAY = 2'd0;
  localparam logic [1:0] S_WON  = 2'd1;
  localparam logic [1:0] S_LOST = 2'd2;

  localparam logic [MOVE_W-1:0] CNT_SAT  = '1;
  localparam logic [MOVE_W-1:0] CNT_LIMIT = MOVE_W'(MAX_MOVES);

  logic [1:0]        state, state_next;
  logic [3:0]        next_pos;
  logic [MOVE_W-1:0] cnt_next;
  logic              legal;
  logic              timeout_next;

  // pos bits: [3]=farmer, [2]=wolf, [1]=goat, [0]=cabbage
  function automatic logic unsafe(input logic [3:0] p);
    return ((p[2] == p[1]) && (p[1] != p[3])) ||
           ((p[1] == p[0]) && (p[1] != p[3]));
  endfunction

  always_comb begin
    legal        = (move_sel == 2'd0) || (pos[2'd3 - move_sel] == pos[3]);
    next_pos     = pos ^ {1'b1, move_sel == 2'd1, move_sel == 2'd2, move_sel == 2'd3};
    cnt_next     = (move_cnt == CNT_SAT) ? move_cnt : move_cnt + 1'b1;
    state_next   = S_PLAY;
    timeout_next = 1'b0;
    // A win on the last allowed move takes precedence over the limit.
    if (next_pos == 4'b1111) begin
      state_next = S_WON;
    end else if (unsafe(next_pos)) begin
      state_next = S_LOST;
    end else if ((TIMEOUT_EN != 0) && (cnt_next == CNT_LIMIT)) begin
      state_next   = S_LOST;
      timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_PLAY;
      pos      <= 4'b0000;
      move_cnt <= '0;
      alarm    <= 1'b0;
      move_err <= 1'b0;
      timeout  <= 1'b0;
    end else if (restart) begin
      state    <= S_PLAY;
      pos      <= 4'b0000;
      move_cnt <= '0;
      alarm    <= 1'b0;
      move_err <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      move_err <= 1'b0;
      if (move_valid) begin
        if ((state != S_PLAY) || !legal) begin
          move_err <= 1'b1;
        end else begin
          pos      <= next_pos;
          move_cnt <= cnt_next;
          alarm    <= unsafe(next_pos);
          state    <= state_next;
          timeout  <= timeout_next;
        end
      end
    end
  end

  assign won  = (state == S_WON);
  assign lost = (state == S_LOST);

endmodule
